// File: rtl/decode_alu1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : decode_alu1
// Description : Registered opcode decoder for ALU stage 1. The 6-bit opcode
//               {Ctrl0..Ctrl5} is looked up in a fixed 15-entry table. The
//               result is an operation index, a carry-in/shift-fill bit and
//               an illegal-opcode flag, all registered with one cycle of
//               latency.
//
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous assert, active-low reset
//               Ctrl0      - opcode bit 5 (MSB); 1 selects shift/rotate class
//               Ctrl1..5   - opcode bits 4..0
//               c_flag     - current carry flag (rotate-through-carry fill)
//               ALU1_out   - registered carry-in / shift-fill bit
//               op_code    - registered operation index (15 = illegal)
//               illegal_op - registered flag, 1 for opcodes not in the table
//
// Config      : ALU1_CARRY_ROTATE_EN - when defined, ROL/ROR drive ALU1_out
//               from c_flag. When undefined, ROL/ROR drive 0 and c_flag is
//               ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module decode_alu1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Ctrl0,
    input  logic       Ctrl1,
    input  logic       Ctrl2,
    input  logic       Ctrl3,
    input  logic       Ctrl4,
    input  logic       Ctrl5,
    input  logic       c_flag,
    output logic       ALU1_out,
    output logic [3:0] op_code,
    output logic       illegal_op
);

    // Opcode encodings
    localparam logic [5:0] c_OP_MOV = 6'b000000;
    localparam logic [5:0] c_OP_ADD = 6'b010010;
    localparam logic [5:0] c_OP_SUB = 6'b010001;
    localparam logic [5:0] c_OP_OR  = 6'b001010;
    localparam logic [5:0] c_OP_NOT = 6'b001100;
    localparam logic [5:0] c_OP_XOR = 6'b001110;
    localparam logic [5:0] c_OP_AND = 6'b000110;
    localparam logic [5:0] c_OP_INC = 6'b011011;
    localparam logic [5:0] c_OP_DEC = 6'b011000;
    localparam logic [5:0] c_OP_SLA = 6'b100100;
    localparam logic [5:0] c_OP_SLL = 6'b100000;
    localparam logic [5:0] c_OP_ROL = 6'b100010;
    localparam logic [5:0] c_OP_SRA = 6'b101100;
    localparam logic [5:0] c_OP_SRL = 6'b101000;
    localparam logic [5:0] c_OP_ROR = 6'b101010;

    // Operation indices
    localparam logic [3:0] c_IDX_MOV     = 4'd0;
    localparam logic [3:0] c_IDX_ADD     = 4'd1;
    localparam logic [3:0] c_IDX_SUB     = 4'd2;
    localparam logic [3:0] c_IDX_OR      = 4'd3;
    localparam logic [3:0] c_IDX_NOT     = 4'd4;
    localparam logic [3:0] c_IDX_XOR     = 4'd5;
    localparam logic [3:0] c_IDX_AND     = 4'd6;
    localparam logic [3:0] c_IDX_INC     = 4'd7;
    localparam logic [3:0] c_IDX_DEC     = 4'd8;
    localparam logic [3:0] c_IDX_SLA     = 4'd9;
    localparam logic [3:0] c_IDX_SLL     = 4'd10;
    localparam logic [3:0] c_IDX_ROL     = 4'd11;
    localparam logic [3:0] c_IDX_SRA     = 4'd12;
    localparam logic [3:0] c_IDX_SRL     = 4'd13;
    localparam logic [3:0] c_IDX_ROR     = 4'd14;
    localparam logic [3:0] c_IDX_ILLEGAL = 4'd15;

    logic [5:0] w_opcode;
    logic       w_rot_fill;
    logic [3:0] w_op_code;
    logic       w_alu1;
    logic       w_illegal;

    logic [3:0] r_op_code;
    logic       r_alu1;
    logic       r_illegal;

    assign w_opcode = {Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5};

    // Fill bit shared by ROL and ROR.
`ifdef ALU1_CARRY_ROTATE_EN
    assign w_rot_fill = c_flag;
`else
    // Rotates fill with 0. c_flag is masked rather than left dangling so the
    // port remains referenced in this build.
    assign w_rot_fill = c_flag & 1'b0;
`endif

    // Table lookup. The default arm covers unlisted opcodes and also any
    // X/Z on the Ctrl inputs, which cannot match a case item in a 4-state
    // simulation.
    always_comb begin
        w_op_code = c_IDX_ILLEGAL;
        w_alu1    = 1'b0;
        w_illegal = 1'b1;
        case (w_opcode)
            c_OP_MOV: begin w_op_code = c_IDX_MOV; w_illegal = 1'b0; end
            c_OP_ADD: begin w_op_code = c_IDX_ADD; w_illegal = 1'b0; end
            c_OP_SUB: begin
                w_op_code = c_IDX_SUB;
                w_alu1    = 1'b1;
                w_illegal = 1'b0;
            end
            c_OP_OR:  begin w_op_code = c_IDX_OR;  w_illegal = 1'b0; end
            c_OP_NOT: begin w_op_code = c_IDX_NOT; w_illegal = 1'b0; end
            c_OP_XOR: begin w_op_code = c_IDX_XOR; w_illegal = 1'b0; end
            c_OP_AND: begin w_op_code = c_IDX_AND; w_illegal = 1'b0; end
            c_OP_INC: begin
                w_op_code = c_IDX_INC;
                w_alu1    = 1'b1;
                w_illegal = 1'b0;
            end
            c_OP_DEC: begin w_op_code = c_IDX_DEC; w_illegal = 1'b0; end
            c_OP_SLA: begin w_op_code = c_IDX_SLA; w_illegal = 1'b0; end
            c_OP_SLL: begin w_op_code = c_IDX_SLL; w_illegal = 1'b0; end
            c_OP_ROL: begin
                w_op_code = c_IDX_ROL;
                w_alu1    = w_rot_fill;
                w_illegal = 1'b0;
            end
            c_OP_SRA: begin w_op_code = c_IDX_SRA; w_illegal = 1'b0; end
            c_OP_SRL: begin w_op_code = c_IDX_SRL; w_illegal = 1'b0; end
            c_OP_ROR: begin
                w_op_code = c_IDX_ROR;
                w_alu1    = w_rot_fill;
                w_illegal = 1'b0;
            end
            default: begin
                w_op_code = c_IDX_ILLEGAL;
                w_alu1    = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Output registers. Reset clears them immediately to MOV. This discards
    // any decode in flight, so the first post-reset result comes from the
    // first rising edge with rst_n high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_code <= c_IDX_MOV;
            r_alu1    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_op_code <= w_op_code;
            r_alu1    <= w_alu1;
            r_illegal <= w_illegal;
        end
    end

    assign op_code    = r_op_code;
    assign ALU1_out   = r_alu1;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_alu1.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_decode_alu1
// Description : Directed self-checking bench for decode_alu1. Each scenario
//               task drives an opcode and compares the registered outputs
//               against hand-computed values. Rotate expectations follow
//               ALU1_CARRY_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_alu1;

    logic       clk;
    logic       rst_n;
    logic       Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5;
    logic       c_flag;
    logic       ALU1_out;
    logic [3:0] op_code;
    logic       illegal_op;

    int checks;
    int errors;

`ifdef ALU1_CARRY_ROTATE_EN
    localparam logic c_ROT_WITH_CARRY = 1'b1;
`else
    localparam logic c_ROT_WITH_CARRY = 1'b0;
`endif

    decode_alu1 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Ctrl0      (Ctrl0),
        .Ctrl1      (Ctrl1),
        .Ctrl2      (Ctrl2),
        .Ctrl3      (Ctrl3),
        .Ctrl4      (Ctrl4),
        .Ctrl5      (Ctrl5),
        .c_flag     (c_flag),
        .ALU1_out   (ALU1_out),
        .op_code    (op_code),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_op(input logic [5:0] op);
        {Ctrl0, Ctrl1, Ctrl2, Ctrl3, Ctrl4, Ctrl5} = op;
    endtask

    // Reset asserted from time zero; outputs must be clear before any edge.
    task automatic test_reset();
        rst_n  = 1'b0;
        c_flag = 1'b1;
        set_op(6'b010001);
        #2;
        checks += 3;
        if (op_code !== 4'd0) begin
            $display("FAIL reset_op_code: got %0d want 0", op_code); errors++;
        end
        if (ALU1_out !== 1'b0) begin
            $display("FAIL reset_alu1: got %b want 0", ALU1_out); errors++;
        end
        if (illegal_op !== 1'b0) begin
            $display("FAIL reset_illegal: got %b want 0", illegal_op); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // All 15 table rows, c_flag=0, one per clock.
    task automatic test_sweep();
        logic [5:0] ops  [15] = '{6'b000000, 6'b010010, 6'b010001, 6'b001010,
                                  6'b001100, 6'b001110, 6'b000110, 6'b011011,
                                  6'b011000, 6'b100100, 6'b100000, 6'b100010,
                                  6'b101100, 6'b101000, 6'b101010};
        logic [3:0] idx  [15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                  4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12,
                                  4'd13, 4'd14};
        logic       fill [15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0};
        c_flag = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            set_op(ops[i]);
            @(posedge clk); #1;
            checks += 3;
            if (op_code !== idx[i]) begin
                $display("FAIL sweep_op_code[%b]: got %0d want %0d",
                         ops[i], op_code, idx[i]); errors++;
            end
            if (ALU1_out !== fill[i]) begin
                $display("FAIL sweep_alu1[%b]: got %b want %b",
                         ops[i], ALU1_out, fill[i]); errors++;
            end
            if (illegal_op !== 1'b0) begin
                $display("FAIL sweep_illegal[%b]: got %b want 0",
                         ops[i], illegal_op); errors++;
            end
        end
    endtask

    // ROL/ROR with c_flag=1. A c_flag change alone must also propagate.
    task automatic test_rotate();
        @(negedge clk);
        set_op(6'b100010);
        c_flag = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (op_code !== 4'd11) begin
            $display("FAIL rol_op_code: got %0d want 11", op_code); errors++;
        end
        if (ALU1_out !== c_ROT_WITH_CARRY) begin
            $display("FAIL rol_alu1: got %b want %b", ALU1_out,
                     c_ROT_WITH_CARRY); errors++;
        end
        @(negedge clk);
        set_op(6'b101010);
        @(posedge clk); #1;
        checks += 2;
        if (op_code !== 4'd14) begin
            $display("FAIL ror_op_code: got %0d want 14", op_code); errors++;
        end
        if (ALU1_out !== c_ROT_WITH_CARRY) begin
            $display("FAIL ror_alu1: got %b want %b", ALU1_out,
                     c_ROT_WITH_CARRY); errors++;
        end
        @(negedge clk);
        c_flag = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ALU1_out !== 1'b0) begin
            $display("FAIL ror_cflag_drop: got %b want 0", ALU1_out); errors++;
        end
    endtask

    // Opcodes outside the table.
    task automatic test_illegal();
        logic [5:0] bad [3] = '{6'b111111, 6'b000001, 6'b110000};
        c_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_op(bad[i]);
            @(posedge clk); #1;
            checks += 3;
            if (op_code !== 4'd15) begin
                $display("FAIL illegal_op_code[%b]: got %0d want 15",
                         bad[i], op_code); errors++;
            end
            if (illegal_op !== 1'b1) begin
                $display("FAIL illegal_flag[%b]: got %b want 1",
                         bad[i], illegal_op); errors++;
            end
            if (ALU1_out !== 1'b0) begin
                $display("FAIL illegal_alu1[%b]: got %b want 0",
                         bad[i], ALU1_out); errors++;
            end
        end
        c_flag = 1'b0;
    endtask

    // Hold SUB, assert reset between edges, then release.
    task automatic test_reset_midstream();
        @(negedge clk);
        set_op(6'b010001);
        @(posedge clk); #1;
        checks += 2;
        if (op_code !== 4'd2 || ALU1_out !== 1'b1) begin
            $display("FAIL midrst_pre: got op %0d alu %b want op 2 alu 1",
                     op_code, ALU1_out); errors++;
        end
        if (illegal_op !== 1'b0) begin
            $display("FAIL midrst_pre_illegal: got %b want 0", illegal_op);
            errors++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (op_code !== 4'd0) begin
            $display("FAIL midrst_op_code: got %0d want 0", op_code); errors++;
        end
        if (ALU1_out !== 1'b0) begin
            $display("FAIL midrst_alu1: got %b want 0", ALU1_out); errors++;
        end
        if (illegal_op !== 1'b0) begin
            $display("FAIL midrst_illegal: got %b want 0", illegal_op); errors++;
        end
        @(posedge clk); #1;
        checks++;
        if (op_code !== 4'd0 || ALU1_out !== 1'b0) begin
            $display("FAIL midrst_held: got op %0d alu %b want op 0 alu 0",
                     op_code, ALU1_out); errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (op_code !== 4'd2) begin
            $display("FAIL midrst_release_op: got %0d want 2", op_code);
            errors++;
        end
        if (ALU1_out !== 1'b1) begin
            $display("FAIL midrst_release_alu1: got %b want 1", ALU1_out);
            errors++;
        end
    endtask

    // ADD -> SUB -> INC on consecutive edges.
    task automatic test_back_to_back();
        logic [5:0] ops  [3] = '{6'b010010, 6'b010001, 6'b011011};
        logic [3:0] idx  [3] = '{4'd1, 4'd2, 4'd7};
        logic       fill [3] = '{1'b0, 1'b1, 1'b1};
        @(negedge clk);
        set_op(ops[0]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks += 2;
            if (ALU1_out !== fill[i]) begin
                $display("FAIL b2b_alu1[%0d]: got %b want %b",
                         i, ALU1_out, fill[i]); errors++;
            end
            if (op_code !== idx[i]) begin
                $display("FAIL b2b_op_code[%0d]: got %0d want %0d",
                         i, op_code, idx[i]); errors++;
            end
            if (i < 2) set_op(ops[i+1]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sweep();
        test_rotate();
        test_illegal();
        test_reset_midstream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
